// File: rtl/spread_pkg.sv
// ---------------------------------------------------------------------------
// spread_pkg
// Shared definitions for the spread_multi DSSS spreader:
//   - FSM state encodings (LOAD, IDLE, SPREAD)
//   - default LFSR width, feedback taps and seed
//   - clamp_len(): folds a requested chips-per-symbol value into [2, max]
// No ports; imported by spread_multi and lfsr_gen.
// ---------------------------------------------------------------------------
package spread_pkg;

    // State encodings are plain constants so older tools can use them too.
    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_SPREAD = 2'd2;

    localparam int          DEF_LFSR_W    = 16;
    localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    // A one-chip "spread" is meaningless, so the floor is two chips; the
    // ceiling is the depth of the code table.
    function automatic int unsigned clamp_len(input int unsigned req,
                                              input int unsigned max_len);
        if (req < 2)
            return 2;
        else if (req > max_len)
            return max_len;
        else
            return req;
    endfunction

endpackage

// File: rtl/spread_multi_lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen
// Galois LFSR producing one pseudo-noise bit per enabled cycle.
// Ports:
//   i_clk      clock
//   i_reset_n  async active-low reset, state returns to LFSR_SEED
//   i_load     synchronous reseed to LFSR_SEED (wins over i_en)
//   i_en       advance the register by one step
//   o_bit      current output bit (LSB of the state)
// ---------------------------------------------------------------------------
module lfsr_gen
    import spread_pkg::*;
#(
    parameter int                LFSR_W    = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
    parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_bit
);

    logic [LFSR_W-1:0] lfsr_q;

    // Galois form: shift right and fold the taps in whenever the bit that
    // falls out of the bottom is a one. Reseeding beats stepping so a reload
    // always restarts the sequence from the same point.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            lfsr_q <= LFSR_SEED;
        else if (i_load)
            lfsr_q <= LFSR_SEED;
        else if (i_en)
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end

    assign o_bit = lfsr_q[0];

endmodule

// File: rtl/spread_multi.sv
// ---------------------------------------------------------------------------
// spread_multi
// DSSS spreader: each accepted CH_N-bit symbol is spread over a run-time
// selectable number of chips by XORing every channel bit with a shared PN
// chip. The PN code is produced once by an internal LFSR into a code table
// and reused for every symbol until a reload regenerates it.
//
// Ports:
//   i_clk       clock
//   i_reset_n   async active-low reset
//   i_code_len  requested chips per symbol (clamped to [2, SPREAD_MAX])
//   i_reload    abort, reseed the LFSR and regenerate the code table
//   i_data      input symbol, one bit per channel
//   i_valid     i_data valid
//   o_ready     symbol can be accepted this cycle (combinational on i_ready)
//   o_data      output chips, one per channel
//   o_valid     o_data valid
//   i_ready     downstream accepts the current chip
//   o_code_ok   code table is loaded
//   o_sym_cnt   completed-symbol counter (only with SPREAD_MULTI_STATS_EN)
//
// Optional feature macro: SPREAD_MULTI_STATS_EN
// ---------------------------------------------------------------------------
module spread_multi
    import spread_pkg::*;
#(
    parameter int                SPREAD_MAX = 64,
    parameter int                CNT_W      = $clog2(SPREAD_MAX + 1),
    parameter int                CH_N       = 1,
    parameter int                LFSR_W     = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = DEF_LFSR_TAPS,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = DEF_LFSR_SEED
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [CNT_W-1:0] i_code_len,
    input  logic             i_reload,
    input  logic [CH_N-1:0]  i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [CH_N-1:0]  o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_code_ok
`ifdef SPREAD_MULTI_STATS_EN
    ,
    output logic [31:0]      o_sym_cnt
`endif
);

    localparam int IDX_W = $clog2(SPREAD_MAX);

    logic [1:0]            state_q;
    logic [CNT_W-1:0]      idx_q;
    logic [CNT_W-1:0]      len_q;
    logic                  need_len_q;
    logic [CH_N-1:0]       sym_q;
    logic [SPREAD_MAX-1:0] code_mem;

    logic [CNT_W-1:0]      clamped_len;
    logic [CNT_W-1:0]      load_len;
    logic                  last_chip;
    logic                  pn_bit;
    logic                  chip_xfer;

    assign clamped_len = CNT_W'(clamp_len(32'(i_code_len), SPREAD_MAX));

    // After reset no length has been taken yet, so the first LOAD cycle
    // uses the live (clamped) request and latches it; a reload latches the
    // length itself on the reload cycle.
    assign load_len  = need_len_q ? clamped_len : len_q;
    assign last_chip = (idx_q == len_q - CNT_W'(1));
    assign chip_xfer = o_valid & i_ready;

    lfsr_gen #(
        .LFSR_W    (LFSR_W),
        .LFSR_TAPS (LFSR_TAPS),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (i_reload),
        .i_en      (state_q == ST_LOAD),
        .o_bit     (pn_bit)
    );

    // Code table: one PN bit per LOAD cycle. Left unreset on purpose; every
    // entry that can be read is rewritten before o_code_ok rises.
    always_ff @(posedge i_clk) begin
        if (state_q == ST_LOAD && !i_reload)
            code_mem[idx_q[IDX_W-1:0]] <= pn_bit;
    end

    // Main FSM, chip counter and symbol register. Reload overrides whatever
    // the FSM was doing and drops any symbol in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_LOAD;
            idx_q      <= '0;
            len_q      <= CNT_W'(SPREAD_MAX);
            need_len_q <= 1'b1;
            sym_q      <= '0;
            o_valid    <= 1'b0;
            o_code_ok  <= 1'b0;
        end else if (i_reload) begin
            state_q    <= ST_LOAD;
            idx_q      <= '0;
            len_q      <= clamped_len;
            need_len_q <= 1'b0;
            o_valid    <= 1'b0;
            o_code_ok  <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (need_len_q) begin
                        len_q      <= load_len;
                        need_len_q <= 1'b0;
                    end
                    if (idx_q == load_len - CNT_W'(1)) begin
                        idx_q     <= '0;
                        o_code_ok <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (i_valid) begin
                        sym_q   <= i_data;
                        idx_q   <= '0;
                        o_valid <= 1'b1;
                        state_q <= ST_SPREAD;
                    end
                end
                ST_SPREAD: begin
                    if (chip_xfer) begin
                        if (last_chip) begin
                            idx_q <= '0;
                            if (i_valid) begin
                                sym_q <= i_data;
                            end else begin
                                o_valid <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                    idx_q   <= '0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

    // Ready while idle, or on the cycle the last chip leaves so the next
    // symbol follows with no bubble.
    assign o_ready = (state_q == ST_IDLE) |
                     ((state_q == ST_SPREAD) & last_chip & i_ready);

    // Gated by o_valid so the chip bus reads zero whenever nothing is valid.
    always_comb begin
        o_data = '0;
        if (o_valid)
            o_data = {CH_N{code_mem[idx_q[IDX_W-1:0]]}} ^ sym_q;
    end

`ifdef SPREAD_MULTI_STATS_EN
    // Completed symbols: a symbol counts once its last chip is accepted.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            o_sym_cnt <= '0;
        else if (i_reload)
            o_sym_cnt <= '0;
        else if (state_q == ST_SPREAD && chip_xfer && last_chip)
            o_sym_cnt <= o_sym_cnt + 32'd1;
    end
`endif

endmodule
